// File: rtl/ram_rr_arbiter_if.sv
// Client and RAM-side signals of the four-way round-robin RAM port arbiter.
// slave is the arbiter view; master is the requester/RAM environment view.
interface ram_rr_arbiter_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 8
);
   logic [3:0]        req;
   logic [3:0]        we;
   logic [3:0]        lock;
   logic [ADDR_W-1:0] addr_0;
   logic [ADDR_W-1:0] addr_1;
   logic [ADDR_W-1:0] addr_2;
   logic [ADDR_W-1:0] addr_3;
   logic [DATA_W-1:0] wdata_0;
   logic [DATA_W-1:0] wdata_1;
   logic [DATA_W-1:0] wdata_2;
   logic [DATA_W-1:0] wdata_3;
   logic [3:0]        gnt;
   logic [3:0]        rvalid;
   logic [DATA_W-1:0] rdata;
   logic              ram_cs;
   logic              ram_wr;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;
   logic              busy;

   modport slave (
      input  req, we, lock, addr_0, addr_1, addr_2, addr_3,
             wdata_0, wdata_1, wdata_2, wdata_3, ram_dout,
      output gnt, rvalid, rdata, ram_cs, ram_wr, ram_addr, ram_din, busy
   );

   modport master (
      output req, we, lock, addr_0, addr_1, addr_2, addr_3,
             wdata_0, wdata_1, wdata_2, wdata_3, ram_dout,
      input  gnt, rvalid, rdata, ram_cs, ram_wr, ram_addr, ram_din, busy
   );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one RAM port among four requesters, with bounded
// burst lock, registered command stage and a two-stage read-tag return pipeline.
module ram_rr_arbiter #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_LOCK = 16
) (
   input logic              clk,
   input logic              rst,
   ram_rr_arbiter_if.slave  bus
);

   localparam logic [7:0] MaxLock = 8'(MAX_LOCK);

   typedef enum logic [0:0] {StArb, StLock} state_e;

   state_e            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        owner_q, owner_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              cs_q, cs_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              v1_q, v1_d, v2_q, v2_d;
   logic [1:0]        id1_q, id1_d, id2_q, id2_d;

   logic              found;
   logic [1:0]        win;
   logic [1:0]        idx;
   logic [3:0]        gnt_c;
   logic [7:0]        cnt_inc;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] wdata_sel;

   always_comb begin
      found   = 1'b0;
      win     = 2'd0;
      idx     = 2'd0;
      gnt_c   = 4'b0000;
      cnt_inc = (cnt_q == MaxLock) ? cnt_q : cnt_q + 8'd1;
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StArb: begin
            for (int k = 0; k < 4; k++) begin
               idx = ptr_q + 2'(k);
               if (!found && bus.req[idx]) begin
                  found = 1'b1;
                  win   = idx;
               end
            end
            if (found) begin
               gnt_c[win] = 1'b1;
               ptr_d      = win + 2'd1;
               // A single-grant limit means the lock never outlives its first grant.
               if (bus.lock[win] && (MaxLock > 8'd1)) begin
                  state_d = StLock;
                  owner_d = win;
                  cnt_d   = 8'd1;
               end
            end
         end
         StLock: begin
            if (bus.req[owner_q]) begin
               found          = 1'b1;
               win            = owner_q;
               gnt_c[owner_q] = 1'b1;
               cnt_d          = cnt_inc;
               if (!bus.lock[owner_q] || (cnt_inc == MaxLock)) state_d = StArb;
            end else begin
               state_d = StArb;
            end
         end
         default: state_d = StArb;
      endcase
   end

   always_comb begin
      addr_sel  = bus.addr_0;
      wdata_sel = bus.wdata_0;
      unique case (win)
         2'd0: begin addr_sel = bus.addr_0; wdata_sel = bus.wdata_0; end
         2'd1: begin addr_sel = bus.addr_1; wdata_sel = bus.wdata_1; end
         2'd2: begin addr_sel = bus.addr_2; wdata_sel = bus.wdata_2; end
         2'd3: begin addr_sel = bus.addr_3; wdata_sel = bus.wdata_3; end
         default: ;
      endcase
      cs_d   = found;
      wr_d   = found & bus.we[win];
      addr_d = found ? addr_sel : addr_q;
      din_d  = found ? wdata_sel : din_q;
      v1_d   = found & ~bus.we[win];
      id1_d  = win;
      v2_d   = v1_q;
      id2_d  = id1_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StArb;
         ptr_q   <= 2'd0;
         owner_q <= 2'd0;
         cnt_q   <= 8'd0;
         cs_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         id1_q   <= 2'd0;
         id2_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         cs_q    <= cs_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         id1_q   <= id1_d;
         id2_q   <= id2_d;
      end
   end

   assign bus.gnt      = rst ? 4'b0000 : gnt_c;
   assign bus.rvalid   = v2_q ? (4'b0001 << id2_q) : 4'b0000;
   assign bus.rdata    = bus.ram_dout;
   assign bus.ram_cs   = cs_q;
   assign bus.ram_wr   = wr_q;
   assign bus.ram_addr = addr_q;
   assign bus.ram_din  = din_q;
   assign bus.busy     = (state_q == StLock);

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter: vector table for round-robin reads plus
// hand sequences for write/read forwarding, lock, wrap and mid-operation reset.
module tb_ram_rr_arbiter;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RAM model: registered read, contents reloaded to a known pattern on reset.
   logic [7:0] mem [1024];
   logic [7:0] dout_q = 8'h00;
   always @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < 1024; a++) mem[a] <= 8'(a) ^ 8'h3C;
      end else if (bus.ram_cs) begin
         if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_din;
         else            dout_q <= mem[bus.ram_addr];
      end
   end
   assign bus.ram_dout = dout_q;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l);
      @(negedge clk);
      bus.req  = r;
      bus.we   = w;
      bus.lock = l;
      #1;
   endtask

   typedef struct {
      logic [3:0] req;
      logic [3:0] we;
      logic [3:0] lock;
      logic [3:0] gnt;
      logic [3:0] rvalid;
      logic       busy;
      logic [7:0] rdata;
   } vec_t;

   vec_t v [11];

   initial begin
      // Reads of addr 0x010/0x020/0x030/0x040 return addr ^ 0x3C.
      v[0]  = '{4'hF, 4'h0, 4'h0, 4'b0001, 4'b0000, 1'b0, 8'h00};
      v[1]  = '{4'hF, 4'h0, 4'h0, 4'b0010, 4'b0000, 1'b0, 8'h00};
      v[2]  = '{4'hF, 4'h0, 4'h0, 4'b0100, 4'b0001, 1'b0, 8'h2C};
      v[3]  = '{4'hF, 4'h0, 4'h0, 4'b1000, 4'b0010, 1'b0, 8'h1C};
      v[4]  = '{4'hF, 4'h0, 4'h0, 4'b0001, 4'b0100, 1'b0, 8'h0C};
      v[5]  = '{4'hF, 4'h0, 4'h0, 4'b0010, 4'b1000, 1'b0, 8'h7C};
      v[6]  = '{4'hF, 4'h0, 4'h0, 4'b0100, 4'b0001, 1'b0, 8'h2C};
      v[7]  = '{4'hF, 4'h0, 4'h0, 4'b1000, 4'b0010, 1'b0, 8'h1C};
      v[8]  = '{4'h0, 4'h0, 4'h0, 4'b0000, 4'b0100, 1'b0, 8'h0C};
      v[9]  = '{4'h0, 4'h0, 4'h0, 4'b0000, 4'b1000, 1'b0, 8'h7C};
      v[10] = '{4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 1'b0, 8'h00};

      bus.req = 4'h0; bus.we = 4'h0; bus.lock = 4'h0;
      bus.addr_0 = 10'h010; bus.addr_1 = 10'h020; bus.addr_2 = 10'h030; bus.addr_3 = 10'h040;
      bus.wdata_0 = 8'h00; bus.wdata_1 = 8'h00; bus.wdata_2 = 8'h00; bus.wdata_3 = 8'h00;

      // Reset state, with requests present.
      @(negedge clk);
      bus.req = 4'hF;
      #1;
      chk("reset gnt", 32'(bus.gnt), 32'h0);
      chk("reset ram_cs", 32'(bus.ram_cs), 32'h0);
      chk("reset ram_wr", 32'(bus.ram_wr), 32'h0);
      chk("reset ram_addr", 32'(bus.ram_addr), 32'h0);
      chk("reset rvalid", 32'(bus.rvalid), 32'h0);
      chk("reset busy", 32'(bus.busy), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.req = 4'h0;

      for (int i = 0; i < 11; i++) begin
         drive(v[i].req, v[i].we, v[i].lock);
         chk($sformatf("vec%0d gnt", i), 32'(bus.gnt), 32'(v[i].gnt));
         chk($sformatf("vec%0d rvalid", i), 32'(bus.rvalid), 32'(v[i].rvalid));
         chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(v[i].busy));
         if (v[i].rvalid != 4'h0)
            chk($sformatf("vec%0d rdata", i), 32'(bus.rdata), 32'(v[i].rdata));
      end

      // Write by 2 then read of same address by 0 returns new data.
      bus.addr_2 = 10'h3FF; bus.wdata_2 = 8'hA5; bus.addr_0 = 10'h3FF;
      drive(4'b0100, 4'b0100, 4'b0000);
      chk("wr gnt", 32'(bus.gnt), 32'b0100);
      drive(4'b0001, 4'b0000, 4'b0000);
      chk("rd gnt", 32'(bus.gnt), 32'b0001);
      chk("wr ram_cs", 32'(bus.ram_cs), 32'h1);
      chk("wr ram_wr", 32'(bus.ram_wr), 32'h1);
      chk("wr ram_addr", 32'(bus.ram_addr), 32'h3FF);
      chk("wr ram_din", 32'(bus.ram_din), 32'hA5);
      drive(4'b0000, 4'b0000, 4'b0000);
      chk("rd ram_wr", 32'(bus.ram_wr), 32'h0);
      chk("wr no rvalid", 32'(bus.rvalid), 32'h0);
      drive(4'b0000, 4'b0000, 4'b0000);
      chk("rd rvalid", 32'(bus.rvalid), 32'b0001);
      chk("rd rdata", 32'(bus.rdata), 32'hA5);
      drive(4'b0000, 4'b0000, 4'b0000);
      chk("idle ram_cs", 32'(bus.ram_cs), 32'h0);
      chk("idle ram_addr hold", 32'(bus.ram_addr), 32'h3FF);
      bus.addr_0 = 10'h010; bus.addr_2 = 10'h030;

      // Lock by 1 bounded at 4 grants, then 3, then 0.
      drive(4'b1011, 4'b0000, 4'b0010);
      chk("lock g1 gnt", 32'(bus.gnt), 32'b0010);
      chk("lock g1 busy", 32'(bus.busy), 32'h0);
      for (int k = 2; k <= 4; k++) begin
         drive(4'b1011, 4'b0000, 4'b0010);
         chk($sformatf("lock g%0d gnt", k), 32'(bus.gnt), 32'b0010);
         chk($sformatf("lock g%0d busy", k), 32'(bus.busy), 32'h1);
      end
      drive(4'b1011, 4'b0000, 4'b0010);
      chk("lock after max gnt", 32'(bus.gnt), 32'b1000);
      chk("lock after max busy", 32'(bus.busy), 32'h0);
      drive(4'b0001, 4'b0000, 4'b0000);
      chk("lock then 0 gnt", 32'(bus.gnt), 32'b0001);
      drive(4'b0000, 4'b0000, 4'b0000);
      chk("lock idle busy", 32'(bus.busy), 32'h0);

      // Lock by 1 released on third grant, arbitration resumes at 2.
      drive(4'b0110, 4'b0000, 4'b0010);
      chk("rel g1 gnt", 32'(bus.gnt), 32'b0010);
      drive(4'b0110, 4'b0000, 4'b0010);
      chk("rel g2 gnt", 32'(bus.gnt), 32'b0010);
      chk("rel g2 busy", 32'(bus.busy), 32'h1);
      drive(4'b0110, 4'b0000, 4'b0000);
      chk("rel g3 gnt", 32'(bus.gnt), 32'b0010);
      chk("rel g3 busy", 32'(bus.busy), 32'h1);
      drive(4'b0110, 4'b0000, 4'b0000);
      chk("rel resume gnt", 32'(bus.gnt), 32'b0100);
      chk("rel resume busy", 32'(bus.busy), 32'h0);
      drive(4'b0000, 4'b0000, 4'b0000);
      chk("idle gnt", 32'(bus.gnt), 32'h0);

      // Idle keeps the pointer at 3; then only 3 requests, wrap to 0.
      drive(4'b0000, 4'b0000, 4'b0000);
      chk("idle2 gnt", 32'(bus.gnt), 32'h0);
      drive(4'b1001, 4'b0000, 4'b0000);
      chk("ptr hold gnt", 32'(bus.gnt), 32'b1000);
      for (int k = 0; k < 3; k++) begin
         drive(4'b1000, 4'b0000, 4'b0000);
         chk($sformatf("only3 c%0d gnt", k), 32'(bus.gnt), 32'b1000);
      end
      drive(4'b0001, 4'b0000, 4'b0000);
      chk("wrap gnt", 32'(bus.gnt), 32'b0001);
      for (int k = 0; k < 3; k++) drive(4'b0000, 4'b0000, 4'b0000);

      // Reset one cycle after a read grant to 3 discards the read.
      drive(4'b1000, 4'b0000, 4'b0000);
      chk("pre-rst gnt", 32'(bus.gnt), 32'b1000);
      drive(4'b0000, 4'b0000, 4'b0000);
      chk("pre-rst ram_cs", 32'(bus.ram_cs), 32'h1);
      rst = 1'b1;
      bus.req = 4'b1000;
      #1;
      chk("rst ram_cs", 32'(bus.ram_cs), 32'h0);
      chk("rst gnt", 32'(bus.gnt), 32'h0);
      chk("rst rvalid", 32'(bus.rvalid), 32'h0);
      @(negedge clk);
      #1;
      chk("rst rvalid2", 32'(bus.rvalid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.req = 4'b0000;
      #1;
      chk("post-rst rvalid0", 32'(bus.rvalid), 32'h0);
      for (int k = 1; k < 3; k++) begin
         drive(4'b0000, 4'b0000, 4'b0000);
         chk($sformatf("post-rst rvalid%0d", k), 32'(bus.rvalid), 32'h0);
      end
      drive(4'b1111, 4'b0000, 4'b0000);
      chk("post-rst ptr gnt", 32'(bus.gnt), 32'b0001);
      drive(4'b0000, 4'b0000, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
